// File: rtl/fir_pkg.sv
// Shared FIR datapath widths plus rounding and saturation helpers for requantizing stages.
package fir_pkg;

  localparam int unsigned FIR_DATA_W = 16;
  localparam int unsigned FIR_ACC_W  = 32;
  localparam int unsigned CALC_W     = 64;

  // Drop `shift` fractional bits, rounding half-up (ties toward +inf).
  function automatic logic signed [CALC_W-1:0] round_half_up(
    input logic signed [CALC_W-1:0] x,
    input int unsigned              shift
  );
    logic signed [CALC_W-1:0] half;
    if (shift == 0) half = '0;
    else            half = CALC_W'(1) << (shift - 1);
    return (x + half) >>> shift;
  endfunction

  function automatic logic signed [CALC_W-1:0] saturate(
    input  logic signed [CALC_W-1:0] x,
    input  int unsigned              out_w,
    output logic                     clipped
  );
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    max_v   = (CALC_W'(1) << (out_w - 1)) - CALC_W'(1);
    min_v   = ~max_v;
    clipped = 1'b0;
    if (x > max_v) begin
      clipped = 1'b1;
      return max_v;
    end
    if (x < min_v) begin
      clipped = 1'b1;
      return min_v;
    end
    return x;
  endfunction

  function automatic logic signed [CALC_W-1:0] sat_round(
    input  logic signed [CALC_W-1:0] x,
    input  int unsigned              shift,
    input  int unsigned              out_w,
    output logic                     clipped
  );
    return saturate(round_half_up(x, shift), out_w, clipped);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             do_wr;
  logic             do_rd;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd      = rd_en && !empty;
  assign do_wr      = wr_en && (!full || do_rd);
  assign wr_ptr_nxt = wr_ptr + (AW+1)'(do_wr);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Head tracks the entry rd_ptr will point at; a write into an otherwise empty FIFO becomes head directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (do_wr && (wr_ptr == rd_ptr_nxt)) rd_data <= wr_data;
      else if (rd_ptr_nxt != wr_ptr)       rd_data <= mem[rd_ptr_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/fir_decim_requant.sv
// Decimates the wide FIR accumulator stream, rounds/saturates kept samples to OUT_W,
// and buffers them behind a valid/ready FIFO with sticky clip and overflow flags.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int unsigned IN_W       = FIR_ACC_W,
  parameter int unsigned OUT_W      = FIR_DATA_W,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  data_in,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flag_clear,
  output logic                    sat_flag,
  output logic                    ovf_flag
);

  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]     phase;
  logic                keep;
  logic                s1_valid;
  logic signed [IN_W:0] s1_r;
  logic [OUT_W-1:0]    wr_data;
  logic                clip_c;
  logic                fifo_full;
  logic                fifo_empty;
  logic                sat_set;
  logic                ovf_set;

  assign keep = in_valid && (phase == '0);

  // Phase counter and stage-1 rounding register (IN_W+1 bits so the rounding add cannot wrap).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_r <= (IN_W+1)'(round_half_up(CALC_W'(data_in), SHIFT));
      if (in_valid) phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
    end
  end

  always_comb begin
    clip_c  = 1'b0;
    wr_data = OUT_W'(saturate(CALC_W'(s1_r), OUT_W, clip_c));
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s1_valid),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (data_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign sat_set   = s1_valid && clip_c;
  // A full FIFO only drops the write when no read frees a slot in the same cycle.
  assign ovf_set   = s1_valid && fifo_full && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      sat_flag <= sat_set || (sat_flag && !flag_clear);
      ovf_flag <= ovf_set || (ovf_flag && !flag_clear);
    end
  end

endmodule

// File: doc/fir_decim_requant.md
# fir_decim_requant

Downstream stage of `fir_standard`. Takes the filter's signed 32-bit accumulator output and decimates it by an integer factor. Each kept sample is rounded and saturated to a signed 16-bit word, then buffered in a small FIFO behind a valid/ready output. It is the point where the full-width FIR result becomes a narrow, back-pressurable sample stream for the next block, such as a DAC interface or logger.

## Interface
- `IN_W`, 32: input width; matches `fir_standard.data_out`.
- `OUT_W`, 16: output width; must satisfy 2 ≤ OUT_W < IN_W.
- `SHIFT`, 15: right-shift (fractional bits dropped); 0 ≤ SHIFT < IN_W.
- `DECIM`, 4: decimation factor, ≥ 1; 1 keeps every sample.
- `FIFO_DEPTH`, 8: output FIFO entries, power of two, ≥ 2.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `data_in`, in, IN_W: signed FIR output.
- `in_valid`, in, 1: `data_in` is valid this cycle. Tie to 1 behind `fir_standard`; there is no input back-pressure.
- `data_out`, out, OUT_W: signed head-of-FIFO sample.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: consumer accepts. The transfer happens when `out_valid && out_ready` at a rising edge.
- `flag_clear`, in, 1: synchronous clear of the sticky flags.
- `sat_flag`, out, 1: sticky; a kept sample was clipped.
- `ovf_flag`, out, 1: sticky; a sample was dropped because the FIFO was full.

## Operation
- **Phase counter**, 0..DECIM-1:
  - Advances on each `in_valid` cycle and wraps to 0 after DECIM-1.
  - A sample is kept when the phase is 0 and `in_valid`. The first valid sample after reset is always kept.
- **Stage 1, round** (registered):
  - Compute `r = (data_in + 2^(SHIFT-1)) >>> SHIFT` at IN_W+1 bits, so the addition cannot wrap.
  - This is round-half-up, i.e. toward +inf on ties.
  - When SHIFT=0 there is no add.
  - Stage 1 carries a valid bit.
- **Stage 2, saturate and write** (combinational into the FIFO write):
  - If `r > 2^(OUT_W-1)-1`, write +max. If `r < -2^(OUT_W-1)`, write -min. Otherwise write `r` truncated to OUT_W.
  - Any clip sets `sat_flag`.
- **FIFO**: first-word-fall-through. `data_out` is the head entry and `out_valid = !empty`.
- **Write when full, no read this cycle**: the new sample is dropped, `ovf_flag` sets, and FIFO contents are unchanged.
- **Write and read in the same cycle while full**: both succeed; no overflow.
- **Write while empty**: no bypass; the sample appears on the next cycle.
- **Read while empty**: ignored.
- **`flag_clear`**: clears both flags. If a set event occurs in the same cycle, set wins.
- **`data_out` while `out_valid=0`**: holds the last value. The value is don't-care and must not be checked.

## Timing
- **Reset values**: `data_out`=0, `out_valid`=0, `sat_flag`=0, `ovf_flag`=0; phase=0; stage-1 valid=0; FIFO empty, pointers 0.
- **Latency**: a sample kept at edge N is in the stage-1 register after N and is written to the FIFO at edge N+1. With the FIFO empty, `out_valid`=1 and `data_out` are valid after edge N+1, giving 2 cycles of latency.
- **Throughput**: one kept sample per cycle when DECIM=1 and `out_ready`=1.
- **Flags**: `sat_flag` and `ovf_flag` assert after the FIFO-write edge N+1.
- **Reset mid-operation**: asserting `reset` asynchronously empties the FIFO and discards stage 1. Outputs drop to their reset values without waiting for a clock. After deassertion the phase restarts at 0.

## Structure
- Shared package `fir_pkg`:
  - `FIR_DATA_W`=16 and `FIR_ACC_W`=32, which `fir_standard` also uses.
  - A `sat_round` function for IN_W to OUT_W conversion, reusable by other requantizing stages.
- Sub-module `sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: `wr_en`, `rd_en`, `full`, `empty`, FWFT head.
  - Pointers have one extra wrap bit.
  - The same `clk`/`reset` convention as this block.
- The top level holds the phase counter, stage 1, saturation and flags.

## Test plan
- **Rounding** (DECIM=1, SHIFT=15, `out_ready`=1):

  | `data_in` | `data_out` |
  |---|---|
  | 32768 | 1 |
  | 16384 | 1 |
  | 16383 | 0 |
  | -16384 | 0 |
  | -16385 | -1 |

  - Each output appears 2 cycles after its input.
- **Saturation**: `data_in`=0x7FFFFFFF gives 32767 and `sat_flag`=1. `data_in`=0x80000000 gives -32768. Pulse `flag_clear` and confirm `sat_flag`=0. Pulse `flag_clear` in the same cycle as a new clip and confirm `sat_flag` stays 1.
- **Decimation** (DECIM=4): `data_in` = k·32768 for k=1..8 on consecutive cycles gives outputs exactly 1 and 5. Repeat with `in_valid` gaps and confirm the phase advances only on valid cycles.
- **Back-pressure**: DECIM=1, `out_ready`=0, FIFO_DEPTH=8, apply 9 samples. Expect 8 stored and `ovf_flag`=1. With `out_ready`=1, samples 1..8 drain in order and the 9th never appears.
- **Full with simultaneous read and write**: no `ovf_flag`, and order is preserved.
- **Reset mid-stream**: assert `reset` with 3 entries queued. Expect `out_valid`=0 immediately, and all flags and outputs at 0. After release, the first valid input is kept, confirming phase 0.
